match_alu_arbiter: RTL

- Shares one combinational opcode-matching ALU between NREQ requesters.
- Each requester presents an operand pair (A, B) over a valid/ready handshake.
- A round-robin arbiter grants one request at a time, latches its operands, evaluates the ALU and returns the result tagged with the requester ID over a valid/ready result port.
- Sits between multiple issuing agents and the single shared match ALU.

---
 rtl/match_pkg.sv | 21 ++
 rtl/match_alu_core.sv | 30 +++
 rtl/match_alu_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// +------------------------------------------------------------------+
// | match_pkg: opcodes and FSM state type for match_alu_arbiter       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package match_pkg;

  localparam int OP_INC = 17;
  localparam int OP_ADD = 21;
  localparam int OP_SUB = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/match_alu_core.sv
// +------------------------------------------------------------------+
// | match_alu_core: combinational ALU whose function is chosen by A   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module match_alu_core
  import match_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_res
);

  always_comb begin
    o_res = i_a * i_b;
    if (i_a == WIDTH'(OP_INC)) begin
      o_res = i_a + WIDTH'(1);
    end else if (i_a == WIDTH'(OP_ADD)) begin
      o_res = i_a + i_b;
    end else if (i_a == WIDTH'(OP_SUB)) begin
      o_res = i_a - i_b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/match_alu_arbiter.sv
// +------------------------------------------------------------------+
// | match_alu_arbiter: round-robin sharing of one match ALU           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module match_alu_arbiter
  import match_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_res_valid,
  output logic [WIDTH-1:0]      o_res_data,
  output logic [IDW-1:0]        o_res_id,
  input  logic                  i_res_ready,
  output logic                  o_busy
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } operand_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  operand_t         r_op;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [IDW-1:0]   r_res_id;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_cand;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_alu;

  // First asserted request strictly after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Reset gates the strobe so no grant is visible while it is held.
  assign w_accept = i_rst_n && w_found &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DONE) && i_res_ready));

  always_comb begin
    o_req_ready = '0;
    if (w_accept) begin
      o_req_ready[w_win] = 1'b1;
    end
  end

  assign w_sel_a = i_req_a[int'(w_win)*WIDTH +: WIDTH];
  assign w_sel_b = i_req_b[int'(w_win)*WIDTH +: WIDTH];

  match_alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a   (r_op.a),
    .i_b   (r_op.b),
    .o_res (w_alu)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_op        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      if (w_accept) begin
        r_ptr  <= w_win;
        r_id   <= w_win;
        r_op.a <= w_sel_a;
        r_op.b <= w_sel_b;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_valid <= 1'b1;
          r_res_data  <= w_alu;
          r_res_id    <= r_id;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= w_accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_id    = r_res_id;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
